vend_change_ctrl: RTL and testbench
===================================

// Module: vend_change_ctrl
// PURPOSE
//   Change-dispense sequencer for the soda vending machine. Accepts a change amount
//   (in nickel units) from the vending FSM and drives a single coin-ejector actuator.
//   Greedy selection is quarter, then dime, then nickel, limited by on-hand inventory.
//   Keeps per-coin inventory counts, refilled by customer coins and decremented on ejection.
// PARAMETERS
//   AMT_W   5  width of change amount, nickel units (max 31 = $1.55)
//   CNT_W   6  width of each inventory counter (saturates at 2**CNT_W-1)
//   INIT_Q  4  quarter count loaded at reset
//   INIT_D  4  dime count loaded at reset
//   INIT_N  4  nickel count loaded at reset
// PORTS
//   clk_i         in   1      clock
//   rst_i         in   1      asynchronous reset, active-high
//   req_valid_i   in   1      change request valid
//   req_amount_i  in   AMT_W  change to return, nickel units
//   req_ready_o   out  1      controller idle; request accepted when valid&ready at posedge
//   coin_in_i     in   3      one-hot {quarter,dime,nickle} inserted-coin pulse, 1 cycle
//   disp_o        out  3      one-hot {quarter,dime,nickel} eject command, held until ack
//   disp_ack_i    in   1      actuator confirms coin dropped
//   done_o        out  1      1-cycle pulse: request finished
//   short_o       out  1      valid with done_o: 1 = could not pay in full
//   remaining_o   out  AMT_W  unpaid amount; valid with done_o
//   exact_only_o  out  1      1 when nickel count == 0 (show "exact change only")
//   q_cnt_o, d_cnt_o, n_cnt_o  out  CNT_W  inventory counts
// BEHAVIOUR
//   Reset (async): state IDLE, rem=0, disp_o=0, done_o=0, short_o=0, remaining_o=0,
//     req_ready_o=1, counts = INIT_Q/INIT_D/INIT_N. disp_o drops immediately on reset.
//   FSM states:
//   - IDLE: req_ready_o=1. On valid&ready, latch rem<=req_amount_i and go to SELECT.
//     req_valid_i while not ready is ignored and not queued.
//   - SELECT (1 cycle):
//     - rem==0 -> DONE, short=0.
//     - rem>=5 & q>0 -> coin=Q; else rem>=2 & d>0 -> coin=D; else n>0 -> coin=N.
//     - No coin fits -> DONE, short=1. Then go to DISPENSE.
//   - DISPENSE: disp_o = coin, no timeout. On disp_ack_i: rem -= value (Q=5, D=2, N=1),
//     decrement that count, go to GAP.
//   - GAP: 1 cycle with disp_o=0, then SELECT. Guarantees a low gap between ejects.
//   - DONE: done_o=1 for one cycle, short_o valid, remaining_o=rem, then IDLE.
//     short_o and remaining_o hold until the next done_o.
//   Latency: request accepted at edge T -> SELECT during T+1 -> disp_o high from T+2.
//     A zero amount gives done_o at T+2.
//   Handshake rules:
//   - disp_ack_i outside DISPENSE is ignored.
//   - Ack in the first DISPENSE cycle is legal.
//   Inventory:
//   - coin_in_i increments the matching count in any state; saturates at max with no wrap.
//   - Same-cycle increment and ejection decrement of one counter gives a net 0 change.
//   - Decrement never underflows: SELECT only picks coins with count>0.
//   - coin_in_i not one-hot (multiple bits set) increments every set counter.
//   - Greedy selection is normative, even where a non-greedy mix could pay in full.
//   - Arithmetic: rem is unsigned AMT_W. Subtraction cannot underflow because of the
//     SELECT guards.
// STRUCTURE
//   vend_pkg holds:
//   - typedef enum coin_e {COIN_N, COIN_D, COIN_Q}
//   - localparams VAL_N=1, VAL_D=2, VAL_Q=5
//   - typedef enum state_e {IDLE, SELECT, DISPENSE, GAP, DONE}
//   Sub-module vend_coin_counter (CNT_W, INIT): saturating up/down counter with
//   inc_i/dec_i/cnt_o, instantiated 3x.
// TESTING
//   1 Reset: counts 4/4/4, req_ready_o=1, disp_o=0, done_o=0, exact_only_o=0.
//   2 Request 6 (30c), ack 1 cycle after each disp_o -> Q then N ejected with a GAP
//     between them; done_o with short_o=0; q=3, n=3.
//   3 Request 4 (20c) -> D, D; done_o short_o=0; d=2; req_valid_i held during the run
//     is ignored.
//   4 INIT_N=0, INIT_D=0, request 1 -> no disp_o; done_o at T+2 with short_o=1,
//     remaining_o=1; exact_only_o=1.
//   5 coin_in_i nickel in the same cycle as nickel ack -> n unchanged.
//     Saturation: 70 nickel pulses -> n_cnt_o=63.
//   6 Assert rst_i mid-DISPENSE -> disp_o=0 the same cycle; IDLE and INIT counts
//     after release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending change dispenser.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_N,
    COIN_D,
    COIN_Q
  } coin_e;

  localparam int VAL_N = 1;
  localparam int VAL_D = 2;
  localparam int VAL_Q = 5;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    DISPENSE,
    GAP,
    DONE
  } state_e;

  // Ejector lines are ordered {quarter,dime,nickel}.
  function automatic logic [2:0] coin_onehot(
    input coin_e c
  );
    logic [2:0] oh;
    case (c)
      COIN_Q:  oh = 3'b100;
      COIN_D:  oh = 3'b010;
      COIN_N:  oh = 3'b001;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/vend_coin_counter.sv
// Saturating inventory counter for one coin type.
// Simultaneous inc and dec cancel out.
module vend_coin_counter #(
  parameter int CNT_W = 6,
  parameter int INIT  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != MAX)
      cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= CNT_W'(INIT);
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vend_change_ctrl.sv
// Change-dispense sequencer: greedy Q/D/N ejection
// limited by on-hand inventory.
module vend_change_ctrl
  import vend_pkg::*;
#(
  parameter int AMT_W  = 5,
  parameter int CNT_W  = 6,
  parameter int INIT_Q = 4,
  parameter int INIT_D = 4,
  parameter int INIT_N = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  input  logic [AMT_W-1:0] req_amount_i,
  output logic             req_ready_o,
  input  logic [2:0]       coin_in_i,
  output logic [2:0]       disp_o,
  input  logic             disp_ack_i,
  output logic             done_o,
  output logic             short_o,
  output logic [AMT_W-1:0] remaining_o,
  output logic             exact_only_o,
  output logic [CNT_W-1:0] q_cnt_o,
  output logic [CNT_W-1:0] d_cnt_o,
  output logic [CNT_W-1:0] n_cnt_o
);

  state_e           state_q;
  logic [AMT_W-1:0] rem_q;
  coin_e            coin_q;
  logic [2:0]       disp_q;
  logic             done_q;
  logic             short_q;
  logic [AMT_W-1:0] remaining_q;
  logic             ready_q;

  logic             sel_ok;
  coin_e            sel_coin;
  logic [AMT_W-1:0] coin_val;
  logic             ack_fire;
  logic [2:0]       dec;

  // Greedy pick; each branch is guarded so rem and counts never underflow.
  always_comb begin
    sel_ok   = 1'b0;
    sel_coin = COIN_N;
    if (rem_q >= AMT_W'(VAL_Q) && q_cnt_o != '0) begin
      sel_ok   = 1'b1;
      sel_coin = COIN_Q;
    end else if (rem_q >= AMT_W'(VAL_D) && d_cnt_o != '0) begin
      sel_ok   = 1'b1;
      sel_coin = COIN_D;
    end else if (n_cnt_o != '0) begin
      sel_ok   = 1'b1;
      sel_coin = COIN_N;
    end
  end

  always_comb begin
    coin_val = AMT_W'(VAL_N);
    unique case (1'b1)
      coin_q == COIN_Q: coin_val = AMT_W'(VAL_Q);
      coin_q == COIN_D: coin_val = AMT_W'(VAL_D);
      default:          coin_val = AMT_W'(VAL_N);
    endcase
  end

  assign ack_fire = (state_q == DISPENSE) && disp_ack_i;
  assign dec      = ack_fire ? coin_onehot(coin_q) : 3'b000;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      coin_q      <= COIN_N;
      disp_q      <= 3'b000;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      remaining_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i && ready_q) begin
            rem_q   <= req_amount_i;
            ready_q <= 1'b0;
            state_q <= SELECT;
          end
        end
        SELECT: begin
          if (rem_q == '0) begin
            done_q      <= 1'b1;
            short_q     <= 1'b0;
            remaining_q <= '0;
            state_q     <= DONE;
          end else if (sel_ok) begin
            coin_q  <= sel_coin;
            disp_q  <= coin_onehot(sel_coin);
            state_q <= DISPENSE;
          end else begin
            done_q      <= 1'b1;
            short_q     <= 1'b1;
            remaining_q <= rem_q;
            state_q     <= DONE;
          end
        end
        DISPENSE: begin
          if (disp_ack_i) begin
            rem_q   <= rem_q - coin_val;
            disp_q  <= 3'b000;
            state_q <= GAP;
          end
        end
        GAP: state_q <= SELECT;
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  vend_coin_counter #(
    .CNT_W(CNT_W),
    .INIT (INIT_Q)
  ) u_q_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(coin_in_i[2]),
    .dec_i(dec[2]),
    .cnt_o(q_cnt_o)
  );

  vend_coin_counter #(
    .CNT_W(CNT_W),
    .INIT (INIT_D)
  ) u_d_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(coin_in_i[1]),
    .dec_i(dec[1]),
    .cnt_o(d_cnt_o)
  );

  vend_coin_counter #(
    .CNT_W(CNT_W),
    .INIT (INIT_N)
  ) u_n_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(coin_in_i[0]),
    .dec_i(dec[0]),
    .cnt_o(n_cnt_o)
  );

  assign req_ready_o  = ready_q;
  assign disp_o       = disp_q;
  assign done_o       = done_q;
  assign short_o      = short_q;
  assign remaining_o  = remaining_q;
  assign exact_only_o = (n_cnt_o == '0);

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Randomized bench for vend_change_ctrl against a greedy
// change-making model with its own inventory.
module tb_vend_change_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [4:0] req_amount;
  logic       req_ready;
  logic [2:0] coin_in;
  logic [2:0] disp;
  logic       ack;
  logic       done;
  logic       short_f;
  logic [4:0] remaining;
  logic       exact;
  logic [5:0] qc, dc, nc;

  logic       req_valid2;
  logic [4:0] req_amount2;
  logic       req_ready2;
  logic [2:0] disp2;
  logic       done2;
  logic       short2;
  logic [4:0] remaining2;
  logic       exact2;
  logic [5:0] qc2, dc2, nc2;

  int checks   = 0;
  int failures = 0;

  int mq, md, mn;
  int exp_seq[$];
  int exp_rem;
  bit exp_short;

  always #5 clk = ~clk;

  vend_change_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_amount_i(req_amount),
    .req_ready_o (req_ready),
    .coin_in_i   (coin_in),
    .disp_o      (disp),
    .disp_ack_i  (ack),
    .done_o      (done),
    .short_o     (short_f),
    .remaining_o (remaining),
    .exact_only_o(exact),
    .q_cnt_o     (qc),
    .d_cnt_o     (dc),
    .n_cnt_o     (nc)
  );

  vend_change_ctrl #(
    .INIT_D(0),
    .INIT_N(0)
  ) dut2 (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid2),
    .req_amount_i(req_amount2),
    .req_ready_o (req_ready2),
    .coin_in_i   (3'b000),
    .disp_o      (disp2),
    .disp_ack_i  (1'b0),
    .done_o      (done2),
    .short_o     (short2),
    .remaining_o (remaining2),
    .exact_only_o(exact2),
    .q_cnt_o     (qc2),
    .d_cnt_o     (dc2),
    .n_cnt_o     (nc2)
  );

  function automatic int disp_val(input logic [2:0] d);
    case (d)
      3'b100:  return 5;
      3'b010:  return 2;
      3'b001:  return 1;
      default: return -1;
    endcase
  endfunction

  // Reference: pay greedily from the model inventory.
  task automatic model_req(input int amt);
    int r;
    r = amt;
    exp_seq.delete();
    while (r > 0) begin
      if (r >= 5 && mq > 0) begin
        exp_seq.push_back(5); mq--; r -= 5;
      end else if (r >= 2 && md > 0) begin
        exp_seq.push_back(2); md--; r -= 2;
      end else if (mn > 0) begin
        exp_seq.push_back(1); mn--; r -= 1;
      end else begin
        break;
      end
    end
    exp_rem   = r;
    exp_short = (r != 0);
  endtask

  task automatic model_coin(input logic [2:0] c);
    if (c[2] && mq < 63) mq++;
    if (c[1] && md < 63) md++;
    if (c[0] && mn < 63) mn++;
  endtask

  // ack_dly < 0 picks a random ack delay per coin.
  task automatic run_req(
    input int    amt,
    input int    ack_dly,
    input bit    hold,
    input bit    spur,
    input string tag
  );
    int         got[$];
    int         cyc, wait_cnt, dly, done_cyc, n;
    logic [2:0] prev;
    model_req(amt);
    @(negedge clk);
    req_valid  = 1'b1;
    req_amount = amt[4:0];
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    cyc = 1; prev = 3'b000; done_cyc = 0;
    wait_cnt = 0; dly = 0;
    while (done_cyc == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (req_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s busy_ready: got %b want 0 cyc %0d",
                 tag, req_ready, cyc);
      end
      if (disp != 3'b000 && prev == 3'b000) begin
        got.push_back(disp_val(disp));
        wait_cnt = 0;
        dly = (ack_dly < 0) ? $urandom_range(0, 3) : ack_dly;
        if (got.size() == 1) begin
          checks++;
          if (cyc != 2) begin
            failures++;
            $display("FAIL %s first_disp_latency: got %0d want 2",
                     tag, cyc);
          end
        end
      end else if (disp != 3'b000) begin
        checks++;
        if (disp !== prev) begin
          failures++;
          $display("FAIL %s disp_hold: got %b want %b",
                   tag, disp, prev);
        end
      end
      if (disp != 3'b000) begin
        ack = (wait_cnt == dly);
        wait_cnt++;
      end else begin
        ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (done) done_cyc = cyc;
      prev = disp;
    end
    ack       = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (done_cyc == 0) begin
      failures++;
      $display("FAIL %s done_timeout: got none want done_o", tag);
    end
    checks++;
    if (got.size() != exp_seq.size()) begin
      failures++;
      $display("FAIL %s coin_count: got %0d want %0d",
               tag, got.size(), exp_seq.size());
    end
    n = (got.size() < exp_seq.size()) ? got.size() : exp_seq.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] != exp_seq[i]) begin
        failures++;
        $display("FAIL %s coin[%0d]: got %0d want %0d",
                 tag, i, got[i], exp_seq[i]);
      end
    end
    if (exp_seq.size() == 0) begin
      checks++;
      if (done_cyc != 2) begin
        failures++;
        $display("FAIL %s nocoin_done_latency: got %0d want 2",
                 tag, done_cyc);
      end
    end
    checks++;
    if (short_f !== exp_short) begin
      failures++;
      $display("FAIL %s short: got %b want %b", tag, short_f, exp_short);
    end
    checks++;
    if (remaining !== exp_rem[4:0]) begin
      failures++;
      $display("FAIL %s remaining: got %0d want %0d",
               tag, remaining, exp_rem);
    end
    checks++;
    if (qc !== mq[5:0] || dc !== md[5:0] || nc !== mn[5:0]) begin
      failures++;
      $display("FAIL %s counts: got %0d/%0d/%0d want %0d/%0d/%0d",
               tag, qc, dc, nc, mq, md, mn);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1 || remaining !== exp_rem[4:0]) begin
      failures++;
      $display("FAIL %s after_done: got done=%b rdy=%b rem=%0d want 0/1/%0d",
               tag, done, req_ready, remaining, exp_rem);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0; req_amount = '0;
    coin_in = 3'b000; ack = 1'b0;
    req_valid2 = 1'b0; req_amount2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mq = 4; md = 4; mn = 4;
    @(negedge clk);
    checks++;
    if (qc !== 6'd4 || dc !== 6'd4 || nc !== 6'd4) begin
      failures++;
      $display("FAIL reset_counts: got %0d/%0d/%0d want 4/4/4",
               qc, dc, nc);
    end
    checks++;
    if (req_ready !== 1'b1 || disp !== 3'b000 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got rdy=%b disp=%b done=%b want 1/000/0",
               req_ready, disp, done);
    end
    checks++;
    if (exact !== 1'b0 || short_f !== 1'b0 || remaining !== 5'd0) begin
      failures++;
      $display("FAIL reset_flags: got ex=%b sh=%b rem=%0d want 0/0/0",
               exact, short_f, remaining);
    end
    checks++;
    if (exact2 !== 1'b1) begin
      failures++;
      $display("FAIL reset_exact2: got %b want 1", exact2);
    end
  endtask

  task automatic test_quarter_nickel;
    run_req(6, 1, 1'b0, 1'b0, "q_then_n");
  endtask

  task automatic test_dimes_held_valid;
    run_req(4, 1, 1'b1, 1'b0, "dimes_held");
  endtask

  task automatic test_exact_only;
    int cyc, done_cyc;
    bit seen;
    @(negedge clk);
    req_valid2 = 1'b1; req_amount2 = 5'd1;
    @(negedge clk);
    req_valid2 = 1'b0;
    cyc = 1; done_cyc = 0; seen = 1'b0;
    while (done_cyc == 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (disp2 != 3'b000) seen = 1'b1;
      if (done2) done_cyc = cyc;
    end
    checks++;
    if (done_cyc != 2) begin
      failures++;
      $display("FAIL exact_done_latency: got %0d want 2", done_cyc);
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL exact_no_disp: got disp want none");
    end
    checks++;
    if (short2 !== 1'b1 || remaining2 !== 5'd1) begin
      failures++;
      $display("FAIL exact_short: got sh=%b rem=%0d want 1/1",
               short2, remaining2);
    end
    checks++;
    if (exact2 !== 1'b1) begin
      failures++;
      $display("FAIL exact_flag: got %b want 1", exact2);
    end
  endtask

  task automatic test_same_cycle_inc_dec;
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_amount = 5'd1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (disp == 3'b000 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (disp !== 3'b001) begin
      failures++;
      $display("FAIL samecyc_disp: got %b want 001", disp);
    end
    ack = 1'b1; coin_in = 3'b001;
    @(negedge clk);
    ack = 1'b0; coin_in = 3'b000;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || short_f !== 1'b0 || remaining !== 5'd0) begin
      failures++;
      $display("FAIL samecyc_done: got d=%b sh=%b rem=%0d want 1/0/0",
               done, short_f, remaining);
    end
    checks++;
    if (nc !== mn[5:0]) begin
      failures++;
      $display("FAIL samecyc_n: got %0d want %0d", nc, mn);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [2:0] c;
    int         k;
    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        @(negedge clk);
        c = 3'($urandom_range(0, 7));
        coin_in = c;
        model_coin(c);
      end
      @(negedge clk);
      coin_in = 3'b000;
      run_req($urandom_range(0, 31), -1, 1'b0, 1'b1, "random");
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      coin_in = 3'b001;
      model_coin(3'b001);
    end
    @(negedge clk);
    coin_in = 3'b000;
    @(negedge clk);
    checks++;
    if (nc !== 6'd63 || mn != 63) begin
      failures++;
      $display("FAIL saturate_n: got %0d want 63", nc);
    end
    checks++;
    if (exact !== 1'b0) begin
      failures++;
      $display("FAIL saturate_exact: got %b want 0", exact);
    end
  endtask

  task automatic test_reset_mid_dispense;
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_amount = 5'd10;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (disp == 3'b000 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (disp === 3'b000) begin
      failures++;
      $display("FAIL midrst_setup: got disp=000 want eject");
    end
    rst = 1'b1;
    #1;
    checks++;
    if (disp !== 3'b000 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_async: got disp=%b rdy=%b want 000/1",
               disp, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    mq = 4; md = 4; mn = 4;
    @(negedge clk);
    checks++;
    if (qc !== 6'd4 || dc !== 6'd4 || nc !== 6'd4 ||
        disp !== 3'b000 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_after: got %0d/%0d/%0d disp=%b rdy=%b want 4/4/4 000 1",
               qc, dc, nc, disp, req_ready);
    end
    run_req(13, 0, 1'b0, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_quarter_nickel();
    test_dimes_held_valid();
    test_exact_only();
    test_same_cycle_inc_dec();
    test_random();
    test_saturation();
    test_reset_mid_dispense();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
